// File: rtl/mux2_arbiter.sv
// rtl/mux2_arbiter.sv - round-robin arbiter driving the select of a shared 2:1 data mux
module mux2_arbiter #(
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    // hold_cnt value at which a contested grant must be handed over
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] hold_cnt;
    logic       last;

    // Next-state decision: alternate on ties, release on drop, force a switch after MAX_HOLD contested cycles
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_nxt = last ? GRANT0 : GRANT1;
                else if (req0)
                    state_nxt = GRANT0;
                else if (req1)
                    state_nxt = GRANT1;
            end
            GRANT0: begin
                if (!req0)
                    state_nxt = req1 ? GRANT1 : IDLE;
                else if (req1 && hold_cnt == HOLD_LAST)
                    state_nxt = GRANT1;
            end
            GRANT1: begin
                if (!req1)
                    state_nxt = req0 ? GRANT0 : IDLE;
                else if (req0 && hold_cnt == HOLD_LAST)
                    state_nxt = GRANT0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, registered grants/select and the hold counter; entering a grant restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            out_valid <= 1'b0;
            sel       <= 1'b0;
            hold_cnt  <= 4'd0;
            last      <= 1'b1;
        end else begin
            state     <= state_nxt;
            gnt0      <= (state_nxt == GRANT0);
            gnt1      <= (state_nxt == GRANT1);
            out_valid <= (state_nxt != IDLE);
            if (state_nxt != IDLE && state_nxt != state) begin
                sel      <= (state_nxt == GRANT1);
                last     <= (state_nxt == GRANT1);
                hold_cnt <= 4'd0;
            end else if (state_nxt != IDLE && hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + 4'd1;
            end
        end
    end

    assign out = sel ? in1 : in0;

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb/tb_mux2_arbiter.sv - randomized and directed self-checking bench for mux2_arbiter
module tb_mux2_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [15:0] in0 = 16'h0;
    logic [15:0] in1 = 16'h0;

    logic        g0a, g1a, sela, ova;
    logic [15:0] outa;
    logic        g0b, g1b, selb, ovb;
    logic [15:0] outb;

    int checks = 0;
    int errors = 0;

    // reference model, index 0 -> MAX_HOLD=4 instance, index 1 -> MAX_HOLD=1 instance
    int m_own[2];
    int m_run[2];
    int m_last[2];
    int m_sel[2];
    int m_max[2] = '{4, 1};

    always #5 clk = ~clk;

    mux2_arbiter #(.WIDTH(16), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .in0(in0), .in1(in1),
        .gnt0(g0a), .gnt1(g1a), .sel(sela), .out(outa), .out_valid(ova)
    );

    mux2_arbiter #(.WIDTH(16), .MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .in0(in0), .in1(in1),
        .gnt0(g0b), .gnt1(g1b), .sel(selb), .out(outb), .out_valid(ovb)
    );

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_own[i] = -1; m_run[i] = 0; m_last[i] = 1; m_sel[i] = 0;
        end
    endtask

    task automatic model_step(input logic r0, input logic r1);
        int r[2];
        int k;
        int nxt;
        r[0] = int'(r0);
        r[1] = int'(r1);
        for (int i = 0; i < 2; i++) begin
            k = m_own[i];
            nxt = k;
            if (k < 0) begin
                if (r[0] == 1 && r[1] == 1) nxt = 1 - m_last[i];
                else if (r[0] == 1) nxt = 0;
                else if (r[1] == 1) nxt = 1;
            end else if (r[k] == 0) begin
                nxt = (r[1-k] == 1) ? 1 - k : -1;
            end else if (r[1-k] == 1 && m_run[i] >= m_max[i]) begin
                nxt = 1 - k;
            end
            if (nxt >= 0 && nxt != k) begin
                m_run[i] = 1; m_last[i] = nxt; m_sel[i] = nxt;
            end else if (nxt >= 0) begin
                m_run[i] = m_run[i] + 1;
            end
            m_own[i] = nxt;
        end
    endtask

    task automatic step(input logic r0, input logic r1, input logic [15:0] d0, input logic [15:0] d1);
        @(negedge clk);
        req0 = r0; req1 = r1; in0 = d0; in1 = d1;
        @(posedge clk);
        model_step(r0, r1);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in0 = 16'h5A5A; in1 = 16'hC3C3;
        model_reset();
        #2;
        checks++;
        if ({g0a, g1a, sela, ova} !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs got %b want 0000", {g0a, g1a, sela, ova});
        end
        checks++;
        if (outa !== 16'h5A5A) begin
            errors++; $display("FAIL reset_out got %h want 5a5a", outa);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lone();
        do_reset();
        step(1'b1, 1'b0, 16'h1234, 16'hABCD);
        checks++;
        if ({g0a, g1a, sela, ova, outa} !== {4'b1001, 16'h1234}) begin
            errors++; $display("FAIL lone_first got %b %h want 1001 1234", {g0a, g1a, sela, ova}, outa);
        end
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b0, 16'h1234, 16'hABCD);
            checks++;
            if ({g0a, g1a, outa} !== {2'b10, 16'h1234}) begin
                errors++; $display("FAIL lone_hold cyc %0d got %b %h want 10 1234", c, {g0a, g1a}, outa);
            end
        end
    endtask

    task automatic test_both_rr();
        logic e0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            step(1'b1, 1'b1, 16'h1234, 16'hABCD);
            e0 = ((c / 4) % 2) == 0;
            checks++;
            if ({g0a, g1a, outa} !== {e0, ~e0, e0 ? 16'h1234 : 16'hABCD}) begin
                errors++; $display("FAIL rr4 cyc %0d got %b %h want %b", c, {g0a, g1a}, outa, {e0, ~e0});
            end
        end
    endtask

    task automatic test_max_hold1();
        logic e0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 1'b1, 16'h1234, 16'hABCD);
            e0 = (c % 2) == 0;
            checks++;
            if ({g0b, g1b, selb, outb} !== {e0, ~e0, ~e0, e0 ? 16'h1234 : 16'hABCD}) begin
                errors++; $display("FAIL rr1 cyc %0d got %b %h want %b", c, {g0b, g1b, selb}, outb, {e0, ~e0, ~e0});
            end
        end
    endtask

    task automatic test_handoff();
        do_reset();
        step(1'b0, 1'b1, 16'h1234, 16'hABCD);
        checks++;
        if ({g0a, g1a, sela} !== 3'b011) begin
            errors++; $display("FAIL handoff_pre got %b want 011", {g0a, g1a, sela});
        end
        step(1'b1, 1'b0, 16'h1234, 16'hABCD);
        checks++;
        if ({g0a, g1a, sela, ova, outa} !== {4'b1001, 16'h1234}) begin
            errors++; $display("FAIL handoff got %b %h want 1001 1234", {g0a, g1a, sela, ova}, outa);
        end
    endtask

    task automatic test_tie_break();
        do_reset();
        step(1'b1, 1'b0, 16'h1111, 16'h2222);
        step(1'b0, 1'b0, 16'h1111, 16'h2222);
        checks++;
        if ({g0a, g1a, ova, sela} !== 4'b0000) begin
            errors++; $display("FAIL tie_idle got %b want 0000", {g0a, g1a, ova, sela});
        end
        step(1'b1, 1'b1, 16'h1111, 16'h2222);
        checks++;
        if ({g0a, g1a} !== 2'b01) begin
            errors++; $display("FAIL tie_after0 got %b want 01", {g0a, g1a});
        end
        step(1'b0, 1'b0, 16'h1111, 16'h2222);
        checks++;
        if ({ova, sela, outa} !== {2'b01, 16'h2222}) begin
            errors++; $display("FAIL tie_idle_sel got %b %h want 01 2222", {ova, sela}, outa);
        end
        step(1'b1, 1'b1, 16'h1111, 16'h2222);
        checks++;
        if ({g0a, g1a} !== 2'b10) begin
            errors++; $display("FAIL tie_after1 got %b want 10", {g0a, g1a});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b0, 1'b1, 16'h1234, 16'hABCD);
        checks++;
        if (g1a !== 1'b1) begin
            errors++; $display("FAIL areset_pre got %b want 1", g1a);
        end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({g0a, g1a, ova, sela, outa} !== {4'b0000, 16'h1234}) begin
            errors++; $display("FAIL areset_drop got %b %h want 0000 1234", {g0a, g1a, ova, sela}, outa);
        end
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1;
        rst_n = 1'b1;
        step(1'b1, 1'b1, 16'h1234, 16'hABCD);
        checks++;
        if ({g0a, g1a, sela} !== 3'b100) begin
            errors++; $display("FAIL areset_first got %b want 100", {g0a, g1a, sela});
        end
    endtask

    task automatic test_random();
        logic r0, r1;
        logic [15:0] d0, d1;
        logic [15:0] eo;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 3) != 0);
            d0 = 16'($urandom);
            d1 = 16'($urandom);
            step(r0, r1, d0, d1);
            eo = (m_sel[0] == 1) ? d1 : d0;
            checks++;
            if ({g0a, g1a, ova, sela, outa} !== {m_own[0] == 0, m_own[0] == 1, m_own[0] >= 0, m_sel[0] == 1, eo}) begin
                errors++;
                $display("FAIL rand_mh4 cyc %0d got %b %h want own %0d sel %0d out %h",
                         c, {g0a, g1a, ova, sela}, outa, m_own[0], m_sel[0], eo);
            end
            eo = (m_sel[1] == 1) ? d1 : d0;
            checks++;
            if ({g0b, g1b, ovb, selb, outb} !== {m_own[1] == 0, m_own[1] == 1, m_own[1] >= 0, m_sel[1] == 1, eo}) begin
                errors++;
                $display("FAIL rand_mh1 cyc %0d got %b %h want own %0d sel %0d out %h",
                         c, {g0b, g1b, ovb, selb}, outb, m_own[1], m_sel[1], eo);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lone();
        test_both_rr();
        test_max_hold1();
        test_handoff();
        test_tie_break();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
Round-robin arbiter that shares one WIDTH-bit 2:1 mux datapath between two requesters. It grants the shared output to one requester at a time and drives the mux select. It bounds how long one requester can hold the output while the other waits. It sits in front of the existing mux2to1-style datapath and is the only driver of its select line.

Parameters:
WIDTH, 16, data width of in0/in1/out
MAX_HOLD, 4, maximum consecutive grant cycles for one requester while the other is requesting (legal range 1..15)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 wants the output; level, held until done
req1  input  1  requester 1 wants the output; level, held until done
in0  input  WIDTH  requester 0 data
in1  input  WIDTH  requester 1 data
gnt0  output  1  requester 0 owns the output this cycle
gnt1  output  1  requester 1 owns the output this cycle
sel  output  1  mux select; 0 = in0, 1 = in1
out  output  WIDTH  shared output; combinational mux of in0/in1 by registered sel
out_valid  output  1  gnt0 | gnt1

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset is asserted asynchronously and released synchronously by the integrator.
  - Reset values: state=IDLE, gnt0=0, gnt1=0, sel=0, out_valid=0, hold_cnt=0, last=1.
  - last=1 means requester 0 wins the first tie.
  - out = in0 during reset.
- Registered state: state, sel, hold_cnt (4 bits), last (id of the most recently granted requester).
- Latency: req is sampled at clk edge n; the resulting gnt/sel are visible after edge n; out follows sel combinationally.
- gnt0 = (state==GRANT0); gnt1 = (state==GRANT1). Never both 1.
- IDLE:
  - Both req -> grant requester !last.
  - Only reqk -> GRANTk.
  - None -> stay; sel holds its last value.
- GRANTk (k = 0 or 1, other = !k):
  - reqk=0 and req_other=1 -> GRANTother.
  - reqk=0 and req_other=0 -> IDLE.
  - reqk=1, req_other=1, hold_cnt==MAX_HOLD-1 -> GRANTother (forced switch).
  - Otherwise stay in GRANTk.
- On every entry to GRANTk: sel<=k, last<=k, hold_cnt<=0.
  - GRANT0 -> GRANT1 is a direct one-edge switch with no idle bubble.
- While staying in GRANTk: hold_cnt increments and saturates at MAX_HOLD-1.
  - A lone requester therefore keeps the grant indefinitely.
  - Once the other requester arrives with hold_cnt already saturated, the switch happens at the next edge.
- MAX_HOLD=1: with both requesting, the grant alternates every cycle.
- Requester dropping req while granted: release takes effect at the next edge; out_valid stays 1 for that cycle (requester ignores it).
- Reset mid-grant: gnt0/gnt1/out_valid drop to 0 immediately (asynchronous), sel=0. After release, arbitration restarts from IDLE with last=1.
- No arithmetic on data; out is a pure select.

Test Plan:
- Reset, then req0=1, req1=0, in0=16'h1234, in1=16'hABCD -> after edge 1: gnt0=1, sel=0, out=16'h1234, out_valid=1. Stays so for 10 cycles (no forced switch).
- From IDLE after reset, raise req0=req1=1 together (MAX_HOLD=4) -> gnt0 for 4 cycles, then gnt1 for 4 cycles, repeating. out alternates 1234/ABCD accordingly; gnt0 and gnt1 are never both 1.
- req1 alone is granted, drop req1 and raise req0 in the same cycle -> next edge gnt0=1, gnt1=0, sel=0, no out_valid gap.
- Tie break: serve req0, drop all (IDLE), then raise both -> gnt1 wins. Repeat with req1 served last -> gnt0 wins.
- Assert rst_n=0 mid-cycle during GRANT1 -> gnt1, out_valid, sel go 0 without a clock edge. Release with both req=1 -> first grant is gnt0.
- Rebuild with MAX_HOLD=1, hold req0=req1=1 -> gnt toggles every cycle: 0,1,0,1...
